// File: rtl/mul_accum_store_if.sv
// Word-pair intake and result-stream bundle for mul_accum_store.
// "slave" is the accumulator's view of the bundle; "master" is the driving side's view.
`timescale 1ns/1ps

interface mul_accum_store_if #(
  parameter int REGISTER_SIZE = 32,
  parameter int PAD_W         = 8
);
  logic [REGISTER_SIZE-1:0] high_in;
  logic [REGISTER_SIZE-1:0] low_in;
  logic [PAD_W-1:0]         start_padding;
  logic                     valid_in;
  logic                     last_in;
  logic                     flush_in;
  logic                     ready_out;
  logic [REGISTER_SIZE-1:0] data_out;
  logic                     valid_out;
  logic                     last_out;
  logic                     ready_in;
  logic                     overflow_out;

  modport slave (
    input  high_in, low_in, start_padding, valid_in, last_in, flush_in, ready_in,
    output ready_out, data_out, valid_out, last_out, overflow_out
  );

  modport master (
    output high_in, low_in, start_padding, valid_in, last_in, flush_in, ready_in,
    input  ready_out, data_out, valid_out, last_out, overflow_out
  );
endinterface

// File: rtl/mul_accum_store.sv
// Accumulates rows of {high,low} partial-product pairs into a wide carry-propagated
// accumulator and streams flushed results LSW-first. Optional: MUL_ACCUM_OVERFLOW_FLAG_EN.
`timescale 1ns/1ps

module mul_accum_store #(
  parameter int REGISTER_SIZE   = 32,
  parameter int NUM_BITS_STORED = 2048,
  parameter int DESIRED_SIZE    = 2080
) (
  input  logic           clk_in,
  input  logic           rst_in,
  mul_accum_store_if.slave bus
);

  localparam int ROW_WORDS = NUM_BITS_STORED / REGISTER_SIZE;
  localparam int ACC_WORDS = DESIRED_SIZE / REGISTER_SIZE;
  localparam int PAD_W     = $clog2(ACC_WORDS) + 1;
  localparam int IDX_W     = $clog2(ACC_WORDS);
  localparam int BEAT_W    = $clog2(ROW_WORDS + 1);
  localparam int SUM_W     = REGISTER_SIZE + 2;

  localparam logic [PAD_W-1:0]  PTR_LAST  = PAD_W'(ACC_WORDS - 1);
  localparam logic [PAD_W-1:0]  PTR_END   = PAD_W'(ACC_WORDS);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(ROW_WORDS - 1);

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_ACCUM,
    ST_TAIL,
    ST_OUTPUT
  } state_t;

  state_t                   state_q, state_d;
  logic [PAD_W-1:0]         ptr_q, ptr_d;
  logic [1:0]               carry_q, carry_d;
  logic [REGISTER_SIZE-1:0] prev_high_q, prev_high_d;
  logic [BEAT_W-1:0]        beat_q, beat_d;
  logic                     flush_q, flush_d;

  logic [REGISTER_SIZE-1:0] acc_mem [ACC_WORDS];
  logic                     mem_we;
  logic [IDX_W-1:0]         mem_idx;
  logic [REGISTER_SIZE-1:0] mem_wdata;

  logic [PAD_W-1:0]         work_addr;
  logic                     addr_ok;
  logic [REGISTER_SIZE-1:0] acc_word;
  logic [REGISTER_SIZE-1:0] add_low;
  logic [SUM_W-1:0]         sum;
  logic                     ready;
  logic                     valid;
  logic                     last_word;
  logic                     beat_fire;
  logic                     out_fire;
  logic                     tail_done;
  logic                     row_end;
  logic [BEAT_W-1:0]        beat_base;

  // The first beat of a row addresses start_padding directly; afterwards the pointer rules.
  assign work_addr = (state_q == ST_IDLE) ? bus.start_padding : ptr_q;
  assign addr_ok   = (work_addr < PTR_END);
  assign acc_word  = addr_ok ? acc_mem[work_addr[IDX_W-1:0]] : '0;
  assign add_low   = (state_q == ST_TAIL) ? '0 : bus.low_in;
  assign sum       = SUM_W'(acc_word) + SUM_W'(add_low) + SUM_W'(prev_high_q) + SUM_W'(carry_q);

  assign ready     = (state_q == ST_IDLE) || (state_q == ST_ACCUM);
  assign valid     = (state_q == ST_OUTPUT);
  assign last_word = valid && (ptr_q == PTR_LAST);
  assign beat_fire = bus.valid_in && ready;
  assign out_fire  = valid && bus.ready_in;
  assign tail_done = ((prev_high_q == '0) && (carry_q == '0)) || !addr_ok;
  assign beat_base = (state_q == ST_IDLE) ? '0 : beat_q;
  assign row_end   = bus.last_in || (beat_base == BEAT_LAST);

  assign bus.ready_out = ready;
  assign bus.valid_out = valid;
  assign bus.last_out  = last_word;
  assign bus.data_out  = valid ? acc_word : '0;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    carry_d     = carry_q;
    prev_high_d = prev_high_q;
    beat_d      = beat_q;
    flush_d     = flush_q;
    mem_we      = 1'b0;
    mem_idx     = work_addr[IDX_W-1:0];
    mem_wdata   = '0;

    case (state_q)
      ST_CLEAR: begin
        mem_we = 1'b1;
        if (ptr_q == PTR_LAST) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end

      ST_IDLE, ST_ACCUM: begin
        if (beat_fire) begin
          // Out-of-range words are silently dropped: the result wraps mod 2^DESIRED_SIZE.
          mem_we      = addr_ok;
          mem_wdata   = sum[REGISTER_SIZE-1:0];
          carry_d     = sum[SUM_W-1:REGISTER_SIZE];
          prev_high_d = bus.high_in;
          ptr_d       = addr_ok ? work_addr + 1'b1 : work_addr;
          if (row_end) begin
            state_d = ST_TAIL;
            beat_d  = '0;
            flush_d = bus.flush_in;
          end else begin
            state_d = ST_ACCUM;
            beat_d  = beat_base + 1'b1;
          end
        end
      end

      ST_TAIL: begin
        if (tail_done) begin
          state_d     = flush_q ? ST_OUTPUT : ST_IDLE;
          ptr_d       = '0;
          carry_d     = '0;
          prev_high_d = '0;
          flush_d     = 1'b0;
        end else begin
          mem_we      = 1'b1;
          mem_wdata   = sum[REGISTER_SIZE-1:0];
          carry_d     = sum[SUM_W-1:REGISTER_SIZE];
          prev_high_d = '0;
          ptr_d       = ptr_q + 1'b1;
        end
      end

      ST_OUTPUT: begin
        // Streamed words are zeroed behind the reader, leaving the array clean for the next row.
        if (out_fire) begin
          mem_we = 1'b1;
          if (ptr_q == PTR_LAST) begin
            state_d = ST_IDLE;
            ptr_d   = '0;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end

      default: state_d = ST_CLEAR;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= ST_CLEAR;
      ptr_q       <= '0;
      carry_q     <= '0;
      prev_high_q <= '0;
      beat_q      <= '0;
      flush_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      carry_q     <= carry_d;
      prev_high_q <= prev_high_d;
      beat_q      <= beat_d;
      flush_q     <= flush_d;
    end
  end

  // NOTE: the array has no reset; the CLEAR walk zeroes it so it can map onto plain storage.
  always_ff @(posedge clk_in) begin
    if (mem_we) begin
      acc_mem[mem_idx] <= mem_wdata;
    end
  end

`ifdef MUL_ACCUM_OVERFLOW_FLAG_EN
  logic ovf_q;
  logic ovf_set;

  always_comb begin
    ovf_set = 1'b0;
    if (beat_fire) begin
      if (!addr_ok && (sum != '0)) ovf_set = 1'b1;
      if ((work_addr == PTR_LAST) && (sum[SUM_W-1:REGISTER_SIZE] != '0)) ovf_set = 1'b1;
    end
    if (state_q == ST_TAIL) begin
      if (!addr_ok && ((prev_high_q != '0) || (carry_q != '0))) ovf_set = 1'b1;
      if (!tail_done && (work_addr == PTR_LAST) && (sum[SUM_W-1:REGISTER_SIZE] != '0)) ovf_set = 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      ovf_q <= 1'b0;
    end else if (out_fire && last_word) begin
      ovf_q <= 1'b0;
    end else if (ovf_set) begin
      ovf_q <= 1'b1;
    end
  end

  assign bus.overflow_out = ovf_q;
`else
  assign bus.overflow_out = 1'b0;
`endif

endmodule

// File: tb/tb_mul_accum_store.sv
// Self-checking bench for mul_accum_store: table of single-pair rows plus hand-written
// multi-cycle sequences, with a scoreboard queue of expected result words.
`timescale 1ns/1ps

module tb_mul_accum_store;

  localparam int ACC_WORDS = 65;

`ifdef MUL_ACCUM_OVERFLOW_FLAG_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        ovf_chk;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [7:0]  pad;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        flush;
    int          base;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
    logic        ovf;
  } vec_t;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic stall_mode = 1'b0;

  int total = 0;
  int bad = 0;
  int hs_count = 0;

  exp_t        exp_q[$];
  logic [31:0] exp_words [ACC_WORDS];
  vec_t        vecs [8];

  mul_accum_store_if #(.REGISTER_SIZE(32), .PAD_W(8)) bus ();

  mul_accum_store #(
    .REGISTER_SIZE  (32),
    .NUM_BITS_STORED(2048),
    .DESIRED_SIZE   (2080)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus   (bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic push_expected(input logic ovf);
    for (int k = 0; k < ACC_WORDS; k++) begin
      exp_t e;
      e.data    = exp_words[k];
      e.last    = (k == ACC_WORDS - 1);
      e.ovf_chk = (k == 0);
      e.ovf     = OVF_EN & ovf;
      exp_q.push_back(e);
    end
  endtask

  task automatic zero_expected();
    for (int k = 0; k < ACC_WORDS; k++) exp_words[k] = '0;
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the beat.
  task automatic send_beat(input logic [7:0] pad, input logic [31:0] lo, input logic [31:0] hi,
                           input logic last, input logic flush);
    int n = 0;
    logic took = 1'b0;
    bus.valid_in      = 1'b1;
    bus.start_padding = pad;
    bus.low_in        = lo;
    bus.high_in       = hi;
    bus.last_in       = last;
    bus.flush_in      = flush;
    do begin
      @(negedge clk_in);
      took = bus.ready_out;
      @(posedge clk_in);
      #1;
      n++;
    end while (!took && n < 500);
    check("beat_accepted", took, 1'b1);
    bus.valid_in = 1'b0;
    bus.last_in  = 1'b0;
    bus.flush_in = 1'b0;
  endtask

  task automatic wait_output_done(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk_in);
      n++;
    end
    #1;
    check({name, "_drained"}, exp_q.size(), 0);
    exp_q.delete();
    check({name, "_valid_after"}, bus.valid_out, 1'b0);
    check({name, "_ready_after"}, bus.ready_out, 1'b1);
  endtask

  // Counts cycles from reset release until ready_out rises; optionally offers ignored beats.
  task automatic clear_check(input string name, input logic garbage);
    int n = 0;
    logic saw_valid = 1'b0;
    bus.valid_in      = garbage;
    bus.start_padding = 8'd0;
    bus.low_in        = 32'hDEAD_BEEF;
    bus.high_in       = 32'h0BAD_F00D;
    bus.last_in       = garbage;
    bus.flush_in      = garbage;
    rst_in = 1'b0;
    do begin
      @(posedge clk_in);
      #1;
      n++;
      if (n == 30) begin
        bus.valid_in = 1'b0;
        bus.last_in  = 1'b0;
        bus.flush_in = 1'b0;
      end
      if (bus.valid_out) saw_valid = 1'b1;
    end while (!bus.ready_out && n < 300);
    check({name, "_clear_cycles"}, n, ACC_WORDS);
    check({name, "_valid_low"}, saw_valid, 1'b0);
  endtask

  // Output monitor: samples on the falling edge, a handshake completes on the next rising edge.
  initial begin : monitor
    logic        held_valid = 1'b0;
    logic [31:0] held_data  = '0;
    logic        held_last  = 1'b0;
    forever begin
      @(negedge clk_in);
      if (rst_in) begin
        held_valid = 1'b0;
      end else begin
        if (held_valid) begin
          check("stall_valid", bus.valid_out, 1'b1);
          check("stall_data", bus.data_out, held_data);
          check("stall_last", bus.last_out, held_last);
        end
        held_valid = 1'b0;
        if (bus.valid_out) begin
          if (bus.ready_in) begin
            hs_count++;
            if (exp_q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL unexpected_output: got %0h, want no output", bus.data_out);
            end else begin
              exp_t e;
              e = exp_q.pop_front();
              check("out_data", bus.data_out, e.data);
              check("out_last", bus.last_out, e.last);
              if (e.ovf_chk) check("overflow", bus.overflow_out, e.ovf);
            end
          end else begin
            held_valid = 1'b1;
            held_data  = bus.data_out;
            held_last  = bus.last_out;
          end
        end
      end
    end
  end

  initial begin : ready_driver
    bus.ready_in = 1'b1;
    forever begin
      @(posedge clk_in);
      #1;
      bus.ready_in = stall_mode ? ~bus.ready_in : 1'b1;
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "simulation did not finish");
  end

  initial begin : stimulus
    vecs[0] = '{8'd0,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0,  32'h0, 32'h0, 32'h0, 1'b0};
    vecs[1] = '{8'd0,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0,  32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h1, 1'b0};
    vecs[2] = '{8'd64, 32'd5,         32'd7,         1'b1, 64, 32'd5, 32'h0, 32'h0, 1'b1};
    vecs[3] = '{8'd3,  32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 3,  32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 1'b0};
    vecs[4] = '{8'd63, 32'h8000_0000, 32'h1,         1'b0, 0,  32'h0, 32'h0, 32'h0, 1'b0};
    vecs[5] = '{8'd63, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 63, 32'h0, 32'h1, 32'h0, 1'b1};
    vecs[6] = '{8'd70, 32'd9,         32'd9,         1'b1, 0,  32'h0, 32'h0, 32'h0, 1'b1};
    vecs[7] = '{8'd70, 32'd0,         32'd0,         1'b1, 0,  32'h0, 32'h0, 32'h0, 1'b0};

    bus.valid_in      = 1'b0;
    bus.last_in       = 1'b0;
    bus.flush_in      = 1'b0;
    bus.start_padding = '0;
    bus.low_in        = '0;
    bus.high_in       = '0;

    repeat (3) @(negedge clk_in);
    check("rst_ready", bus.ready_out, 1'b0);
    check("rst_valid", bus.valid_out, 1'b0);
    check("rst_last", bus.last_out, 1'b0);
    check("rst_overflow", bus.overflow_out, 1'b0);
    check("rst_data", bus.data_out, 32'h0);
    clear_check("boot", 1'b0);

    // 64-pair row, low=i, last and flush on the 64th beat.
    for (int k = 0; k < ACC_WORDS; k++) exp_words[k] = (k < 64) ? 32'(k) : 32'h0;
    push_expected(1'b0);
    for (int i = 0; i < 64; i++) send_beat(8'd0, 32'(i), 32'h0, i == 63, i == 63);
    wait_output_done("row64");

    // Single-pair rows from the table.
    for (int v = 0; v < 8; v++) begin
      if (vecs[v].flush) begin
        zero_expected();
        if (vecs[v].base < ACC_WORDS)     exp_words[vecs[v].base]     = vecs[v].w0;
        if (vecs[v].base + 1 < ACC_WORDS) exp_words[vecs[v].base + 1] = vecs[v].w1;
        if (vecs[v].base + 2 < ACC_WORDS) exp_words[vecs[v].base + 2] = vecs[v].w2;
        push_expected(vecs[v].ovf);
      end
      send_beat(vecs[v].pad, vecs[v].lo, vecs[v].hi, 1'b1, vecs[v].flush);
      if (vecs[v].flush) wait_output_done($sformatf("vec%0d", v));
    end

    // 64-pair row again, result drained against a toggling ready_in.
    hs_count = 0;
    stall_mode = 1'b1;
    for (int k = 0; k < ACC_WORDS; k++) exp_words[k] = (k < 64) ? 32'(k) : 32'h0;
    push_expected(1'b0);
    for (int i = 0; i < 64; i++) send_beat(8'd0, 32'(i), 32'h0, i == 63, i == 63);
    wait_output_done("stall");
    repeat (3) @(posedge clk_in);
    #1;
    check("stall_handshakes", hs_count, ACC_WORDS);
    stall_mode = 1'b0;

    // Reset in the middle of a row, then a fresh one-pair row.
    for (int i = 0; i < 10; i++) send_beat(8'd0, 32'hAAAA_0000 + 32'(i), 32'(i + 1), 1'b0, 1'b0);
    check("mid_ready_before", bus.ready_out, 1'b1);
    rst_in = 1'b1;
    #1;
    check("mid_rst_ready", bus.ready_out, 1'b0);
    check("mid_rst_valid", bus.valid_out, 1'b0);
    check("mid_rst_overflow", bus.overflow_out, 1'b0);
    repeat (2) @(negedge clk_in);
    clear_check("mid", 1'b1);
    zero_expected();
    exp_words[0] = 32'd3;
    push_expected(1'b0);
    send_beat(8'd0, 32'd3, 32'd0, 1'b1, 1'b1);
    wait_output_done("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
